// File: rtl/key_conditioner.sv
// key_conditioner: per-key 2-flop sync, debounce and press/release pulses; auto-repeat when KEY_CONDITIONER_REPEAT_EN is defined
module key_conditioner #(
  parameter int NKEYS           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  if (NKEYS < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2)
    $error("key_conditioner: parameter out of range");
  logic [NKEYS-1:0] s1, sync, lvl, acc, fire;
  logic [CW-1:0] cnt [NKEYS];
  // two-flop synchronizer, inverted so 1 means pressed
  always_ff @(posedge clk)
    if (sclr) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= ~key_n;
      sync <= s1;
    end
  // acceptance: sync has disagreed with the level for DEBOUNCE_CYCLES samples
  always_comb
    for (int i = 0; i < NKEYS; i++)
      acc[i] = sync[i] != lvl[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
  // debounce counters restart on any agreement, so bounces never accumulate
  always_ff @(posedge clk)
    for (int i = 0; i < NKEYS; i++)
      cnt[i] <= sclr || sync[i] == lvl[i] || acc[i] ? '0 : cnt[i] + 1'b1;
  // internal debounced level, one cycle ahead of the registered output
  always_ff @(posedge clk)
    lvl <= sclr ? '0 : lvl ^ acc;
`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam int RM = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RM + 1);
  logic [RW-1:0] rcnt [NKEYS];
  logic [NKEYS-1:0] rep;
  // first repeat waits REPEAT_DELAY after the press pulse, later ones REPEAT_PERIOD
  always_comb
    for (int i = 0; i < NKEYS; i++)
      fire[i] = key_level[i] && rcnt[i] == (rep[i] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  // repeat counters run only while the key is held and accepted
  always_ff @(posedge clk)
    for (int i = 0; i < NKEYS; i++) begin
      rcnt[i] <= sclr || !key_level[i] || !lvl[i] || fire[i] ? '0 : rcnt[i] + 1'b1;
      rep[i]  <= sclr || !key_level[i] || !lvl[i] ? 1'b0 : rep[i] | fire[i];
    end
`else
  assign fire = '0;
`endif
  // registered outputs; press and release are edges of the internal level
  always_ff @(posedge clk)
    if (sclr) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_level   <= lvl;
      key_press   <= lvl & (~key_level | fire);
      key_release <= ~lvl & key_level;
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: table-driven, scoreboarded check of key_conditioner with DEBOUNCE_CYCLES=4
module tb_key_conditioner;
  logic clk = 1'b0;
  logic sclr;
  logic [2:0] key_n, key_level, key_press, key_release;
  key_conditioner #(.NKEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
    .clk(clk), .sclr(sclr), .key_n(key_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );
  always #5 clk = ~clk;
`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  typedef struct {
    logic       s;
    logic [2:0] k;
    logic [2:0] l;
    logic [2:0] p;
    logic [2:0] r;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0;
  int failures = 0;
  task automatic seg(input int n, input logic s, input logic [2:0] k, l, p, r);
    repeat (n) tbl.push_back('{s, k, l, p, r});
  endtask
  task automatic chk(input string name, input int row, input logic [2:0] a, e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s row %0d: got %b expected %b", name, row, a, e);
    end
  endtask
  initial begin
    vec_t e;
    sclr = 1'b1;
    key_n = 3'b111;
    seg(2, 1, 3'b111, 3'b000, 3'b000, 3'b000);
    seg(3, 0, 3'b111, 3'b000, 3'b000, 3'b000);
    seg(6, 0, 3'b100, 3'b000, 3'b000, 3'b000);
    seg(1, 0, 3'b100, 3'b011, 3'b011, 3'b000);
    seg(6, 0, 3'b111, 3'b011, 3'b000, 3'b000);
    seg(1, 0, 3'b111, 3'b000, 3'b000, 3'b011);
    seg(3, 0, 3'b111, 3'b000, 3'b000, 3'b000);
    seg(3, 0, 3'b101, 3'b000, 3'b000, 3'b000);
    seg(1, 0, 3'b111, 3'b000, 3'b000, 3'b000);
    seg(6, 0, 3'b101, 3'b000, 3'b000, 3'b000);
    seg(1, 0, 3'b101, 3'b010, 3'b010, 3'b000);
    seg(1, 0, 3'b101, 3'b010, 3'b000, 3'b000);
    seg(6, 0, 3'b111, 3'b010, 3'b000, 3'b000);
    seg(1, 0, 3'b111, 3'b000, 3'b000, 3'b010);
    seg(3, 0, 3'b111, 3'b000, 3'b000, 3'b000);
    seg(6, 0, 3'b011, 3'b000, 3'b000, 3'b000);
    seg(1, 0, 3'b011, 3'b100, 3'b100, 3'b000);
    seg(1, 0, 3'b011, 3'b100, 3'b000, 3'b000);
    seg(6, 0, 3'b111, 3'b100, 3'b000, 3'b000);
    seg(1, 0, 3'b111, 3'b000, 3'b000, 3'b100);
    seg(3, 0, 3'b111, 3'b000, 3'b000, 3'b000);
    seg(5, 0, 3'b110, 3'b000, 3'b000, 3'b000);
    seg(2, 1, 3'b110, 3'b000, 3'b000, 3'b000);
    seg(6, 0, 3'b110, 3'b000, 3'b000, 3'b000);
    seg(1, 0, 3'b110, 3'b001, 3'b001, 3'b000);
    for (int j = 1; j <= 36; j++)
      seg(1, 0, j <= 30 ? 3'b110 : 3'b111, 3'b001,
          (REP && j >= 10 && (j - 10) % 3 == 0) ? 3'b001 : 3'b000, 3'b000);
    seg(1, 0, 3'b111, 3'b000, 3'b000, 3'b001);
    seg(3, 0, 3'b111, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      sclr = tbl[i].s;
      key_n = tbl[i].k;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("key_level", i, key_level, e.l);
      chk("key_press", i, key_press, e.p);
      chk("key_release", i, key_release, e.r);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter NKEYS, default 3, number of independent key channels (>=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, stable samples needed to accept a change (>=2; 20 ms at 50 MHz).
REQ-003 Parameter REPEAT_DELAY, default 25_000_000, clocks from accepted press to first repeat pulse (>=2; used only with REQ-026).
REQ-004 Parameter REPEAT_PERIOD, default 5_000_000, clocks between subsequent repeat pulses (>=2; used only with REQ-026).
REQ-005 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-006 Port: sclr  input  1  reset, synchronous, active-high.
REQ-007 Port: key_n  input  NKEYS  raw board keys, active-low, asynchronous to clk, bouncing.
REQ-008 Port: key_level  output  NKEYS  debounced state per key, 1 = pressed.
REQ-009 Port: key_press  output  NKEYS  one-cycle pulse per accepted press (plus repeats with REQ-026); drives counter load/dir/sclr strobes.
REQ-010 Port: key_release  output  NKEYS  one-cycle pulse per accepted release.

Function
REQ-011 Each key_n bit SHALL pass through a private 2-flop synchronizer and be inverted; the synchronized value (sync) is the only value debounce logic sees.
REQ-012 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1); channels are fully independent.
REQ-013 sync == key_level: counter cleared to 0 the next edge.
REQ-014 sync != key_level and counter < DEBOUNCE_CYCLES-1: counter increments.
REQ-015 sync != key_level and counter == DEBOUNCE_CYCLES-1: key_level toggles, counter clears, same edge.
REQ-016 Any bounce back to sync == key_level before acceptance SHALL discard the partial count (no accumulation across bounces).
REQ-017 Latency: a clean raw edge held steady SHALL change key_level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the new raw value.
REQ-018 key_press SHALL be registered and high for exactly the one cycle in which key_level first reads 1; key_release likewise on the cycle key_level first reads 0.
REQ-019 key_press and key_release of the same channel SHALL never be high together; different channels may pulse in the same cycle.
REQ-020 Pulses shorter than DEBOUNCE_CYCLES samples SHALL produce no output change.
REQ-021 All outputs SHALL be registered; no combinational path from key_n to any output.

Reset
REQ-022 With sclr=1 at a rising edge: synchronizer flops, key_level, key_press, key_release, debounce and repeat counters all SHALL become 0 (released).
REQ-023 sclr SHALL take priority over every other event, including an acceptance due on the same edge.
REQ-024 A key held through reset SHALL be re-accepted as a fresh press DEBOUNCE_CYCLES+2 edges after the first edge with sclr=0.
REQ-025 Outputs SHALL be 0 during and on the first cycle after reset.

Configuration
REQ-026 Macro KEY_CONDITIONER_REPEAT_EN defined: per-channel repeat counter; while key_level=1, extra key_press pulses REPEAT_DELAY clocks after the press pulse, then every REPEAT_PERIOD clocks; release or sclr clears the counter and stops repeats immediately.
REQ-027 Macro undefined: no repeat counter or logic synthesized; exactly one key_press per accepted press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NKEYS=3)
REQ-028 key_n[0] 1->0 clean at edge T -> key_level[0]=1 and key_press[0]=1 at T+6, key_press[0]=0 at T+7.
REQ-029 key_n[1] low 3 cycles, high 1, low 3, then steady low -> no pulse during bounce; key_press[1] exactly once, 6 edges after final steady low.
REQ-030 key_n[2] released after accepted press -> key_release[2] one cycle at release+6; key_press[2] stays 0.
REQ-031 sclr=1 for 2 cycles on edge where key_level[0] would rise, key still held -> all outputs 0; key_press[0] 6 edges after sclr drops.
REQ-032 With KEY_CONDITIONER_REPEAT_EN, key_n[0] held 30 cycles after acceptance at P -> key_press[0] at P, P+10, P+13, P+16, ... until release; without macro, only at P.
REQ-033 Keys 0 and 1 pressed on same edge -> key_press[0] and key_press[1] both high in the same single cycle.
